compare_arbiter: RTL and testbench

- Shares one 3-bit unsigned magnitude comparator among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on both the request and response sides.
- Operands are registered before the compare and the six relation flags are registered after it, so every result comes from a timing-clean path.
- Sits between client blocks (sorters, threshold checkers) and the shared comparator datapath.

---
 rtl/compare_pkg.sv | 39 +++
 rtl/compare_core.sv | 17 +
 rtl/compare_arbiter.sv | 141 ++++++++++++++
 tb/tb_compare_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// compare_pkg: shared definitions for the compare arbiter slice.
//   - FSM state encoding (two bits; 2'b11 is unused and recovers to idle)
//   - Bit positions of the six relation flags in rsp_flags
//   - Default operand width of the comparator datapath
//   - Helper that assembles the flag vector from the three primary relations
package compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPARE = 2'b01,
    ST_RESPOND = 2'b10
  } state_t;

  localparam int FLG_GT = 5;
  localparam int FLG_GE = 4;
  localparam int FLG_LT = 3;
  localparam int FLG_LE = 2;
  localparam int FLG_EQ = 1;
  localparam int FLG_NE = 0;

  localparam int DEFAULT_WIDTH = 3;

  // Derives all six flags from equality and less-than so that exactly one
  // of GT/EQ/LT is set by construction.
  function automatic logic [5:0] make_flags(input logic isEq, input logic isLt);
    logic [5:0] f;
    logic le;
    le = isLt | isEq;
    f = '0;
    f[FLG_EQ] = isEq;
    f[FLG_NE] = ~isEq;
    f[FLG_LT] = isLt;
    f[FLG_LE] = le;
    f[FLG_GT] = ~le;
    f[FLG_GE] = ~le | isEq;
    return f;
  endfunction

endpackage

// File: rtl/compare_core.sv
// compare_core: purely combinational unsigned magnitude comparator.
// Ports:
//   a, b   : WIDTH-bit unsigned operands
//   flags  : {aGTb, aGEb, aLTb, aLEb, aEQb, aNEb}, bit 5 down to bit 0
module compare_core
  import compare_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [5:0]       flags
);

  assign flags = make_flags(a == b, a < b);

endmodule

// File: rtl/compare_arbiter.sv
// compare_arbiter: shares one compare_core among NUM_REQ requesters.
// Round-robin arbitration on the request side, registered operands before
// the compare and registered flags after it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is raised combinationally in IDLE for the round-robin
// winner only; the requester keeps req_valid and operands stable until then.
// rsp_valid, rsp_id and rsp_flags hold steady until the edge where rsp_ready
// is seen high.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   req_valid      : per-requester request strobe
//   req_ready      : per-requester grant (at most one bit high)
//   req_a, req_b   : operands, requester i uses slice [i*WIDTH +: WIDTH]
//   rsp_valid      : result available
//   rsp_ready      : consumer accepts the result
//   rsp_id         : requester index owning the result
//   rsp_flags      : {GT, GE, LT, LE, EQ, NE}
//   dbgState       : current FSM state (debug observation)
//   stat_eq_count  : saturating count of equal results handed off
//                    (present only with COMPARE_ARBITER_STATS_EN defined)
module compare_arbiter
  import compare_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [5:0]               rsp_flags,
  output state_t                   dbgState
`ifdef COMPARE_ARBITER_STATS_EN
  ,
  output logic [7:0]               stat_eq_count
`endif
);

  state_t           state;
  logic [IDW-1:0]   rrPtr;
  logic [IDW-1:0]   idReg;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [5:0]       coreFlags;

  logic             anyReq;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   nextPtr;

  assign dbgState = state;

  // Round-robin search. Walking the offsets from farthest to nearest lets
  // the last hit be the first requester at or after rrPtr.
  always_comb begin
    anyReq = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rrPtr) + k) % NUM_REQ]) begin
        anyReq = 1'b1;
        winner = IDW'((int'(rrPtr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && anyReq) begin
      req_ready = NUM_REQ'(1) << winner;
    end
  end

  assign nextPtr = (idReg == IDW'(NUM_REQ - 1)) ? '0 : idReg + 1'b1;

  compare_core #(.WIDTH(WIDTH)) u_core (
    .a     (opA),
    .b     (opB),
    .flags (coreFlags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rrPtr     <= '0;
      idReg     <= '0;
      opA       <= '0;
      opB       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            opA   <= req_a[int'(winner) * WIDTH +: WIDTH];
            opB   <= req_b[int'(winner) * WIDTH +: WIDTH];
            idReg <= winner;
            state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          rsp_flags <= coreFlags;
          rsp_id    <= idReg;
          rsp_valid <= 1'b1;
          state     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rrPtr     <= nextPtr;
            state     <= ST_IDLE;
          end
        end
        default: begin
          // Unused encoding: drop any stale response and restart.
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef COMPARE_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_eq_count <= '0;
    end else if (state == ST_RESPOND && rsp_ready && rsp_flags[FLG_EQ]
                 && stat_eq_count != 8'hFF) begin
      stat_eq_count <= stat_eq_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compare_arbiter.sv
module tb_compare_arbiter;
  import compare_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 3;
  localparam int IDW     = 2;
  localparam int AW      = NUM_REQ * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cycCount = 0;
  always @(posedge clk) cycCount <= cycCount + 1;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [AW-1:0]      req_a;
  logic [AW-1:0]      req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [5:0]         rsp_flags;
  state_t             dbgState;
`ifdef COMPARE_ARBITER_STATS_EN
  logic [7:0]         stat_eq_count;
`endif

  compare_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_flags (rsp_flags),
    .dbgState  (dbgState)
`ifdef COMPARE_ARBITER_STATS_EN
    ,
    .stat_eq_count (stat_eq_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [IDW+5:0] exp_q[$];   // {id, flags} in expected response order
  int checks = 0;
  int errors = 0;
  int modelPtr = 0;           // reference round-robin pointer
  int expEqCount = 0;         // reference statistics counter
  int grantCyc = 0;           // cycle stamp of the latest grant
  int readyMode = 0;          // 0 random, 1 always ready, 2 stall 5 cycles

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference flags straight from the relational definitions.
  function automatic logic [5:0] ref_flags(input int a, input int b);
    return {a > b, a >= b, a < b, a <= b, a == b, a != b};
  endfunction

  // ---------------- driver ----------------
  // Presents all requesters in mask at once, each dropping its request once
  // granted. The model predicts the grant order from its own pointer.
  task automatic run_batch(input logic [NUM_REQ-1:0] mask,
                           input logic [AW-1:0] av, input logic [AW-1:0] bv);
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] eg;
    int ord[$];
    int lastId;
    int budget;
    int prevGrant;
    lastId = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (modelPtr + k) % NUM_REQ;
      if (mask[i]) begin
        int a;
        int b;
        a = int'(av[i*WIDTH +: WIDTH]);
        b = int'(bv[i*WIDTH +: WIDTH]);
        ord.push_back(i);
        exp_q.push_back({IDW'(i), ref_flags(a, b)});
        if (a == b && expEqCount < 255) expEqCount++;
        lastId = i;
      end
    end
    if (lastId >= 0) modelPtr = (lastId + 1) % NUM_REQ;

    @(posedge clk); #1;
    req_a = av;
    req_b = bv;
    req_valid = mask;
    pend = mask;
    budget = 0;
    prevGrant = -1;
    while (pend != 0 && budget < 300) begin
      @(negedge clk);
      g = req_ready;
      if (g != 0) begin
        eg = '0;
        if (ord.size() != 0) eg[ord.pop_front()] = 1'b1;
        check("grant_order", 32'(g), 32'(eg));
        grantCyc = cycCount;
        if (readyMode == 1 && prevGrant >= 0)
          check("grant_spacing", 32'(cycCount - prevGrant), 32'd3);
        prevGrant = cycCount;
        @(posedge clk); #1;
        req_valid = req_valid & ~g;
        pend = pend & ~g;
        @(negedge clk);
        check("ready_in_compare", 32'(req_ready), 32'd0);
      end else begin
        budget++;
      end
    end
    if (pend != 0) begin
      check("grant_timeout", 32'(pend), 32'd0);
      req_valid = '0;
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      check("response_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int validCycles;
    validCycles = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        validCycles = 0;
        check("valid_in_reset", 32'(rsp_valid), 32'd0);
      end else if (rsp_valid) begin
        validCycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_response", {24'd0, 2'(rsp_id), rsp_flags}, 32'hFFFF_FFFF);
        end else begin
          check("response", 32'({rsp_id, rsp_flags}), 32'(exp_q[0]));
          if (validCycles == 1)
            check("latency", 32'(cycCount - grantCyc), 32'd2);
          check("one_relation",
                32'($countones({rsp_flags[FLG_GT], rsp_flags[FLG_EQ], rsp_flags[FLG_LT]})), 32'd1);
        end
        check("ready_while_busy", 32'(req_ready), 32'd0);
        case (readyMode)
          1:       rsp_ready = 1'b1;
          2:       rsp_ready = (validCycles > 5);
          default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
        if (rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          validCycles = 0;
        end
      end else begin
        validCycles = 0;
        // Ready while no response is pending must be ignored by the DUT.
        rsp_ready = (readyMode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [AW-1:0] av;
    logic [AW-1:0] bv;
    int budget;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_state", 32'(dbgState), 32'(ST_IDLE));
`ifdef COMPARE_ARBITER_STATS_EN
    check("rst_stat", 32'(stat_eq_count), 32'd0);
`endif
    rst = 1'b0;

    // Single request, A=5 B=3 through requester 0.
    readyMode = 1;
    av = '0; bv = '0;
    av[0 +: WIDTH] = 3'd5; bv[0 +: WIDTH] = 3'd3;
    run_batch(4'b0001, av, bv);
    check("flags_5_3", 32'(ref_flags(5, 3)), 32'b110001);

    // Equality / less-than / greater-than corners through requester 3.
    av = '0; bv = '0;
    av[3*WIDTH +: WIDTH] = 3'd3; bv[3*WIDTH +: WIDTH] = 3'd3;
    run_batch(4'b1000, av, bv);
    av[3*WIDTH +: WIDTH] = 3'd0; bv[3*WIDTH +: WIDTH] = 3'd7;
    run_batch(4'b1000, av, bv);
    av[3*WIDTH +: WIDTH] = 3'd7; bv[3*WIDTH +: WIDTH] = 3'd0;
    run_batch(4'b1000, av, bv);

    // Round robin with all requesters, twice to see the wrap back to 0.
    for (int r = 0; r < 2; r++) begin
      run_batch(4'b1111, AW'($urandom), AW'($urandom));
    end

    // Backpressure: consumer stalls five cycles per response.
    readyMode = 2;
    run_batch(4'b0110, AW'($urandom), AW'($urandom));

    // Reset while requester 2 sits in COMPARE; leave the model pointer at 2
    // first so a pointer that survives reset would be visible.
    readyMode = 1;
    run_batch(4'b0010, AW'($urandom), AW'($urandom));
    @(posedge clk); #1;
    req_a = AW'($urandom);
    req_b = AW'($urandom);
    req_valid = 4'b0100;
    budget = 0;
    while (req_ready[2] !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("reset_test_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("midrst_state", 32'(dbgState), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    modelPtr = 0;
    expEqCount = 0;
    run_batch(4'b0101, AW'($urandom), AW'($urandom));

    // Exhaustive operand pairs through requester 1, counter cleared first.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelPtr = 0;
    expEqCount = 0;
    readyMode = 0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        av = '0; bv = '0;
        av[WIDTH +: WIDTH] = WIDTH'(a);
        bv[WIDTH +: WIDTH] = WIDTH'(b);
        run_batch(4'b0010, av, bv);
      end
    end
`ifdef COMPARE_ARBITER_STATS_EN
    check("stat_after_exhaustive", 32'(stat_eq_count), 32'd8);
`endif

    // Random batches with random consumer behaviour.
    for (int n = 0; n < 40; n++) begin
      readyMode = $urandom_range(0, 2);
      run_batch(NUM_REQ'($urandom_range(1, 15)), AW'($urandom), AW'($urandom));
    end

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef COMPARE_ARBITER_STATS_EN
    check("stat_final", 32'(stat_eq_count), 32'(expEqCount));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
